bus_cycle_unit: RTL and testbench



---
 rtl/bus_cycle_unit.sv | 169 ++++++++++++++++
 tb/tb_bus_cycle_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_unit.sv
// Bus interface unit: sequences T1/T2/TW/T3 machine cycles onto a multiplexed
// address/data bus, with READY wait states, timeout and HOLD/HLDA arbitration.
module bus_cycle_unit #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              phi1,
    input  logic              resetn_in,
    input  logic              req,
    input  logic [2:0]        cyc_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              req_ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-DATA_W-1:0] haddress,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in,
    output logic              ALE,
    output logic              S0,
    output logic              S1,
    output logic              IOMn,
    output logic              RDn,
    output logic              WRn,
    input  logic              ready,
    input  logic              hold,
    output logic              hlda,
    output logic              bus_oe
);

    localparam int HI_W  = ADDR_W - DATA_W;
    localparam int REP   = (HI_W + DATA_W - 1) / DATA_W;
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_HLD} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_type;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_timeout;

    logic                w_ready_eff, w_legal, w_accept, w_illegal, w_timeout_hit;
    logic                w_rd, w_io;
    logic [1:0]          w_status;
    logic [REP*DATA_W-1:0] w_rep;
    logic [HI_W-1:0]     w_hi;

    // MAX_WAIT==0 treats READY as permanently asserted
    assign w_ready_eff   = (MAX_WAIT == 0) ? 1'b1 : ready;
    assign w_legal       = (cyc_type <= 3'd4);
    assign req_ready     = ((r_state == S_IDLE) || (r_state == S_T3)) && !hold;
    assign w_accept      = req && req_ready && w_legal;
    assign w_illegal     = req && req_ready && !w_legal;
    assign w_timeout_hit = (r_state == S_TW) && !w_ready_eff && (r_cnt == CNT_W'(MAX_WAIT));

    assign w_rd     = (r_type == 3'd0) || (r_type == 3'd1) || (r_type == 3'd3);
    assign w_io     = (r_type == 3'd3) || (r_type == 3'd4);
    assign w_status = (r_type == 3'd0) ? 2'b11 : (w_rd ? 2'b10 : 2'b01);
    assign w_rep    = {REP{r_addr[DATA_W-1:0]}};
    assign w_hi     = w_io ? w_rep[HI_W-1:0] : r_addr[ADDR_W-1:DATA_W];
    assign rdata    = r_rdata;

    always_ff @(posedge phi1 or negedge resetn_in) begin
        if (!resetn_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = hold ? S_HLD : (w_accept ? S_T1 : S_IDLE);
            S_T1:    w_next = S_T2;
            S_T2:    w_next = w_ready_eff ? S_T3 : S_TW;
            S_TW:    w_next = (w_ready_eff || w_timeout_hit) ? S_T3 : S_TW;
            S_T3:    w_next = hold ? S_HLD : (w_accept ? S_T1 : S_IDLE);
            S_HLD:   w_next = hold ? S_HLD : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge phi1 or negedge resetn_in) begin
        if (!resetn_in) begin
            r_addr    <= '0;
            r_type    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= addr;
                r_type    <= cyc_type;
                r_wdata   <= wdata;
                r_timeout <= 1'b0;
            end
            if ((r_state == S_T2) && !w_ready_eff) begin
                r_cnt <= CNT_W'(1);
            end else if ((r_state == S_TW) && !w_ready_eff && !w_timeout_hit) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            if (((r_state == S_T2) || (r_state == S_TW)) && w_ready_eff && w_rd) begin
                r_rdata <= ad_in;
            end
        end
    end

    always_comb begin
        ALE      = 1'b0;
        RDn      = 1'b1;
        WRn      = 1'b1;
        IOMn     = 1'b0;
        S1       = 1'b0;
        S0       = 1'b0;
        ad_oe    = 1'b0;
        ad_out   = '0;
        haddress = '0;
        bus_oe   = 1'b1;
        hlda     = 1'b0;
        ack      = 1'b0;
        err      = w_illegal;
        if ((r_state == S_T1) || (r_state == S_T2) || (r_state == S_TW) || (r_state == S_T3)) begin
            {S1, S0} = w_status;
            IOMn     = w_io;
            haddress = w_hi;
        end
        case (r_state)
            S_T1: begin
                ALE    = 1'b1;
                ad_oe  = 1'b1;
                ad_out = r_addr[DATA_W-1:0];
            end
            S_T2, S_TW: begin
                if (w_rd) begin
                    RDn = 1'b0;
                end else begin
                    WRn    = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = r_wdata;
                end
            end
            S_T3: begin
                ack = 1'b1;
                err = r_timeout || w_illegal;
                if (!w_rd) begin
                    ad_oe  = 1'b1;
                    ad_out = r_wdata;
                end
            end
            S_HLD: begin
                bus_oe = 1'b0;
                hlda   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Scoreboard bench for bus_cycle_unit: the driver pushes the expected completion
// of each request; a negedge monitor pops and checks whenever ack or err appears.
module tb_bus_cycle_unit;

    localparam int MW = 3;

    logic        phi1, resetn_in, req, ready, hold;
    logic [2:0]  cyc_type;
    logic [15:0] addr;
    logic [7:0]  wdata, ad_in;
    logic        req_ready, ack, err, ad_oe, ALE, S0, S1, IOMn, RDn, WRn, hlda, bus_oe;
    logic [7:0]  rdata, haddress, ad_out;

    bus_cycle_unit #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(MW)) dut (
        .phi1(phi1), .resetn_in(resetn_in), .req(req), .cyc_type(cyc_type),
        .addr(addr), .wdata(wdata), .req_ready(req_ready), .ack(ack),
        .rdata(rdata), .err(err), .haddress(haddress), .ad_out(ad_out),
        .ad_oe(ad_oe), .ad_in(ad_in), .ALE(ALE), .S0(S0), .S1(S1),
        .IOMn(IOMn), .RDn(RDn), .WRn(WRn), .ready(ready), .hold(hold),
        .hlda(hlda), .bus_oe(bus_oe)
    );

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        bit         err;
        bit         illegal;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] last_rdata = 8'h00;

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;
    always @(posedge phi1) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_status(input logic [2:0] t);
        case (t)
            3'd0:       return 2'b11;
            3'd1, 3'd3: return 2'b10;
            default:    return 2'b01;
        endcase
    endfunction

    function automatic bit is_read(input logic [2:0] t);
        return (t == 3'd0) || (t == 3'd1) || (t == 3'd3);
    endfunction

    function automatic bit is_io(input logic [2:0] t);
        return (t == 3'd3) || (t == 3'd4);
    endfunction

    always @(negedge phi1) begin
        if (resetn_in && (ack || err)) begin
            if (q.size() == 0) begin
                chk("unexpected_ack_err", {30'd0, ack, err}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_ack", ack, !e.illegal);
                chk("resp_err", err, e.err);
                if (!e.illegal) chk("resp_rdata", rdata, e.rdata);
            end
        end
    end

    // w = number of READY-low samples before READY rises; w > MW forces a timeout
    task automatic do_txn(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd,
                          input int w, input logic [7:0] din, input bit hold_tw, output int e0);
        int         n, lw;
        bit         rd, to;
        logic [7:0] cap;
        exp_t       e;
        req = 1'b1; cyc_type = t; addr = a; wdata = wd; ready = 1'b1;
        n = 0;
        do begin
            @(negedge phi1);
            n++;
        end while (!req_ready && n < 50);
        e0 = cyc;
        chk("accept_wait", req_ready, 1'b1);
        if (!req_ready) return;
        @(posedge phi1); #1;
        e0 = cyc;
        req = 1'b0;
        rd  = is_read(t);
        to  = (w > MW);
        lw  = to ? MW : w;
        cap = last_rdata;
        ad_in = 8'($urandom);
        chk("t1_ale", ALE, 1'b1);
        chk("t1_ad_oe", ad_oe, 1'b1);
        chk("t1_ad_out", ad_out, a[7:0]);
        chk("t1_haddress", haddress, is_io(t) ? a[7:0] : a[15:8]);
        chk("t1_status", {S1, S0}, exp_status(t));
        chk("t1_iomn", IOMn, is_io(t));
        for (int j = 1; j <= 1 + lw; j++) begin
            @(posedge phi1); #1;
            ready = ((j - 1) >= w);
            ad_in = ((j - 1) == w) ? din : 8'($urandom);
            if ((j - 1) == w) cap = ad_in;
            if (hold_tw && j == 2) hold = 1'b1;
            chk("data_ale", ALE, 1'b0);
            chk("data_rdn", RDn, !rd);
            chk("data_wrn", WRn, rd);
            chk("data_ad_oe", ad_oe, !rd);
            if (!rd) chk("data_ad_out", ad_out, wd);
            chk("data_status", {S1, S0}, exp_status(t));
        end
        @(posedge phi1); #1;
        ready = 1'b1;
        if (rd && !to) last_rdata = cap;
        e.cyc = e0 + 2 + lw; e.rdata = last_rdata; e.err = to; e.illegal = 1'b0;
        q.push_back(e);
        chk("t3_strobes", {RDn, WRn}, 2'b11);
        chk("t3_ad_oe", ad_oe, !rd);
        if (!rd) chk("t3_ad_out", ad_out, wd);
    endtask

    // Called one step after an edge that left the unit in IDLE with hold low
    task automatic do_illegal(input logic [2:0] t);
        exp_t e;
        req = 1'b1; cyc_type = t; addr = 16'($urandom);
        e.cyc = cyc; e.rdata = last_rdata; e.err = 1'b1; e.illegal = 1'b1;
        q.push_back(e);
        @(posedge phi1); #1;
        req = 1'b0;
        chk("illegal_no_ale", ALE, 1'b0);
        chk("illegal_no_strobe", {RDn, WRn}, 2'b11);
        @(posedge phi1); #1;
        chk("illegal_still_idle", ALE, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0a, e0b, tmp;
        resetn_in = 1'b0; req = 1'b0; cyc_type = 3'd0; addr = '0; wdata = '0;
        ad_in = '0; ready = 1'b1; hold = 1'b0;
        repeat (3) @(posedge phi1);
        #1;
        chk("rst_rdn_wrn", {RDn, WRn}, 2'b11);
        chk("rst_ale_adoe", {ALE, ad_oe}, 2'b00);
        chk("rst_bus_oe", bus_oe, 1'b1);
        chk("rst_ack_err_hlda", {ack, err, hlda}, 3'b000);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_haddress", haddress, 8'h00);
        #2 resetn_in = 1'b1;
        @(posedge phi1); #1;
        chk("idle_req_ready", req_ready, 1'b1);
        chk("idle_status", {IOMn, S1, S0}, 3'b000);

        do_txn(3'd1, 16'h1234, 8'h00, 0, 8'hA5, 1'b0, tmp);
        @(posedge phi1); #1;
        chk("after_read_rdata", rdata, 8'hA5);

        do_txn(3'd4, 16'h0080, 8'h5C, 2, 8'h00, 1'b0, tmp);
        @(posedge phi1); #1;

        do_txn(3'd1, 16'h4321, 8'h00, MW + 1, 8'h11, 1'b0, tmp);
        @(posedge phi1); #1;
        chk("timeout_rdata_kept", rdata, 8'hA5);

        do_txn(3'd0, 16'h0000, 8'h00, 0, 8'h3C, 1'b0, e0a);
        do_txn(3'd0, 16'h0001, 8'h00, 0, 8'hC3, 1'b0, e0b);
        chk("b2b_ale_spacing", e0b - e0a, 3);
        @(posedge phi1); #1;

        do_txn(3'd1, 16'h2468, 8'h00, 2, 8'h77, 1'b1, tmp);
        chk("hold_t3_hlda", hlda, 1'b0);
        req = 1'b1; cyc_type = 3'd2; addr = 16'h1357; wdata = 8'h99;
        chk("hold_t3_req_ready", req_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge phi1); #1;
            chk("hld_hlda", hlda, 1'b1);
            chk("hld_bus_oe", bus_oe, 1'b0);
            chk("hld_ale_adoe", {ALE, ad_oe}, 2'b00);
            chk("hld_req_ready", req_ready, 1'b0);
        end
        hold = 1'b0;
        @(posedge phi1); #1;
        chk("hold_release_hlda", hlda, 1'b0);
        chk("hold_release_bus_oe", bus_oe, 1'b1);
        chk("hold_release_idle_ale", ALE, 1'b0);
        do_txn(3'd2, 16'h1357, 8'h99, 1, 8'h00, 1'b0, tmp);
        @(posedge phi1); #1;

        req = 1'b1; cyc_type = 3'd1; addr = 16'hBEEF;
        @(posedge phi1); #1;
        req = 1'b0;
        @(posedge phi1); #1;
        ready = 1'b0;
        chk("pre_reset_rdn", RDn, 1'b0);
        #2 resetn_in = 1'b0;
        #1;
        chk("mid_reset_rdn", RDn, 1'b1);
        chk("mid_reset_ale_adoe", {ALE, ad_oe}, 2'b00);
        chk("mid_reset_ack", ack, 1'b0);
        chk("mid_reset_rdata", rdata, 8'h00);
        last_rdata = 8'h00;
        ready = 1'b1;
        @(posedge phi1); #3;
        resetn_in = 1'b1;
        @(posedge phi1); #1;
        do_illegal(3'b110);

        for (int i = 0; i < 40; i++) begin
            int kind, idle;
            kind = $urandom_range(0, 5);
            if (kind == 5) begin
                @(posedge phi1); #1;
                do_illegal(3'($urandom_range(5, 7)));
            end else begin
                idle = $urandom_range(0, 2);
                repeat (idle) begin @(posedge phi1); #1; end
                do_txn(3'(kind), 16'($urandom), 8'($urandom), $urandom_range(0, MW + 1),
                       8'($urandom), 1'b0, tmp);
            end
        end

        repeat (5) @(posedge phi1);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
